// File: rtl/uart_rx_byte_if.sv
// uart_rx_byte_if: serial line plus received-byte outputs of the UART receiver.
// Signals:
//   rx          serial line, idle high (driven by the line side)
//   rx_data     last good byte
//   rx_valid    one-cycle pulse coincident with an rx_data update
//   rx_busy     receiver is inside a frame
//   frame_err   sticky stop-bit error
//   parity_err  sticky parity error
// Modports: slave = receiver side, master = line driver / byte consumer side.
interface uart_rx_byte_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_busy;
  logic                 frame_err;
  logic                 parity_err;

  modport slave (
    input  rx,
    output rx_data,
    output rx_valid,
    output rx_busy,
    output frame_err,
    output parity_err
  );

  modport master (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  frame_err,
    input  parity_err
  );
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: oversampling UART receiver, 8N1 by default, 8E1 when the macro
// UART_RX_PARITY_EN is defined (parity_err is tied low otherwise).
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    uart_rx_byte_if.slave: rx in; rx_data, rx_valid, rx_busy, frame_err,
//          parity_err out
// rx_data and rx_valid are updated on one single edge per good byte so a downstream
// edge-capture stage sees one consistent change.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8
) (
  input logic           clk,
  input logic           reset,
  uart_rx_byte_if.slave bus
);
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StCommit,
    StWaitHigh
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rxs_q;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 frame_err_q, frame_err_d;
  logic                 tick;

`ifdef UART_RX_PARITY_EN
  logic                 parity_err_q, parity_err_d;
  logic                 parity_bad_q, parity_bad_d;
`endif

  assign tick = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      parity_bad_q <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= bus.rx;
      rxs_q        <= rx_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
      parity_bad_q <= parity_bad_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = tick ? cnt_q : cnt_q - CntW'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    frame_err_d  = frame_err_q;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
    parity_bad_d = parity_bad_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
`ifdef UART_RX_PARITY_EN
          parity_bad_d = 1'b0;
`endif
        end
      end
      StStart: begin
        // Mid-start-bit sample; a high line here was a glitch, not a frame.
        if (tick) begin
          if (!rxs_q) begin
            state_d   = StData;
            cnt_d     = FullLoad;
            bit_idx_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (tick) begin
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = FullLoad;
          if (bit_idx_q == LastIdx) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IdxW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        // Even parity: data bits plus parity bit must hold an even number of ones.
        if (tick) begin
          state_d = StStop;
          cnt_d   = FullLoad;
          if ((^shift_q) != rxs_q) begin
            parity_bad_d = 1'b1;
            parity_err_d = 1'b1;
          end
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
            state_d = parity_bad_q ? StIdle : StCommit;
`else
            state_d = StCommit;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end
      end
      StCommit: begin
        data_d      = shift_q;
        valid_d     = 1'b1;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = 1'b0;
`endif
        state_d     = StIdle;
      end
      StWaitHigh: begin
        // Stay out of IDLE while the line is held low (break) so it is not taken as a start.
        if (rxs_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.rx_busy   = busy_q;
  assign bus.frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: self-checking bench for uart_rx_byte (CLKS_PER_BIT=16).
// A queue of expected bytes (with due cycles) is filled from the frames sent; a negedge
// compare process checks every rx_valid pulse and the held rx_data each cycle.
module tb_uart_rx_byte;
  localparam int unsigned CPB = 16;
  localparam int unsigned DB  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif

  typedef struct {
    logic [DB-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   n_valid = 0;

  exp_t          exp_q[$];
  logic [DB-1:0] m_data = '0;
  bit            m_fe = 1'b0;
  bit            m_pe = 1'b0;

  uart_rx_byte_if #(.DATA_BITS(DB)) bus ();

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Compare process: byte stream against the expected queue, every cycle.
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (reset) begin
      m_data = '0;
      exp_q.delete();
    end else if (bus.rx_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid actual=1 required=0 data=%0h (cycle %0d)",
                 bus.rx_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rx_data_on_valid", 32'(bus.rx_data), 32'(e.data));
        d = cyc - e.due;
        total++;
        if (d < -2 || d > 2) begin
          bad++;
          $display("FAIL valid_latency actual=%0d required=%0d+/-2", cyc, e.due);
        end
        m_data = e.data;
      end
    end else begin
      chk("rx_data_hold", 32'(bus.rx_data), 32'(m_data));
    end
  end

  // Drive rx to v for n cycles; always entered and left at posedge+1.
  task automatic line(input bit v, input int n);
    bus.rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_frame_err"}, 32'(bus.frame_err), 32'(m_fe));
    chk({tag, "_parity_err"}, 32'(bus.parity_err), 32'(m_pe));
  endtask

  // One frame: start, data LSB first, optional parity, stop (low stretched by low_hold when bad).
  task automatic send_frame(input logic [DB-1:0] data, input bit par_ok, input bit stop,
                            input int low_hold, input int gap);
    int   fall;
    exp_t e;
    fall = cyc;
    if (stop && par_ok) begin
      e.data = data;
      e.due  = fall + int'((DB + 1 + PB) * CPB + CPB / 2 + 3);
      exp_q.push_back(e);
    end
    line(1'b0, CPB);
    for (int i = 0; i < DB; i++) begin
      line(data[i], CPB);
      if (i == 0) chk("rx_busy_mid", 32'(bus.rx_busy), 32'd1);
    end
    if (PB != 0) line((^data) ^ !par_ok, CPB);
    if (stop) begin
      line(1'b1, CPB);
      if (par_ok) begin
        m_fe = 1'b0;
        m_pe = 1'b0;
      end else begin
        m_pe = 1'b1;
      end
      chk("rx_busy_after_stop", 32'(bus.rx_busy), 32'd0);
    end else begin
      line(1'b0, CPB + low_hold);
      m_fe = 1'b1;
      if (!par_ok) m_pe = 1'b1;
    end
    chk("pulse_seen", 32'(exp_q.size()), 32'd0);
    chk_flags("frame");
    line(1'b1, gap);
    if (gap >= 4) chk("rx_busy_idle", 32'(bus.rx_busy), 32'd0);
  endtask

  task automatic false_start(input int n);
    int nv;
    nv = n_valid;
    line(1'b0, n);
    line(1'b1, 10);
    chk("false_start_busy", 32'(bus.rx_busy), 32'd0);
    chk("false_start_no_pulse", 32'(n_valid - nv), 32'd0);
    chk_flags("false_start");
    line(1'b1, 4);
  endtask

  initial begin
    int nv;
    logic [DB-1:0] v5a;
    bus.rx = 1'b1;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rx_data", 32'(bus.rx_data), 32'd0);
    chk("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("reset_rx_busy", 32'(bus.rx_busy), 32'd0);
    chk("reset_frame_err", 32'(bus.frame_err), 32'd0);
    reset = 1'b0;
    line(1'b1, 8);

    // 0xA5 good frame
    nv = n_valid;
    send_frame(8'hA5, 1'b1, 1'b1, 0, 8);
    chk("a5_pulses", 32'(n_valid - nv), 32'd1);
    chk("a5_data", 32'(bus.rx_data), 32'hA5);
    chk("a5_frame_err", 32'(bus.frame_err), 32'd0);

    false_start(4);
    chk("false_start_data", 32'(bus.rx_data), 32'hA5);

    // 0x3C with stop=0 and line low 40 more cycles, then 0x01
    nv = n_valid;
    send_frame(8'h3C, 1'b1, 1'b0, 40, 8);
    chk("bad_stop_frame_err", 32'(bus.frame_err), 32'd1);
    chk("bad_stop_data", 32'(bus.rx_data), 32'hA5);
    chk("bad_stop_pulses", 32'(n_valid - nv), 32'd0);
    send_frame(8'h01, 1'b1, 1'b1, 0, 8);
    chk("x01_data", 32'(bus.rx_data), 32'h01);
    chk("x01_frame_err", 32'(bus.frame_err), 32'd0);

    // Back-to-back 0x00, 0xFF
    nv = n_valid;
    send_frame(8'h00, 1'b1, 1'b1, 0, 0);
    chk("b2b_first_data", 32'(bus.rx_data), 32'h00);
    send_frame(8'hFF, 1'b1, 1'b1, 0, 8);
    chk("b2b_pulses", 32'(n_valid - nv), 32'd2);
    chk("b2b_data", 32'(bus.rx_data), 32'hFF);

`ifdef UART_RX_PARITY_EN
    nv = n_valid;
    send_frame(8'h07, 1'b0, 1'b1, 0, 8);
    chk("par_bad_err", 32'(bus.parity_err), 32'd1);
    chk("par_bad_pulses", 32'(n_valid - nv), 32'd0);
    send_frame(8'h07, 1'b1, 1'b1, 0, 8);
    chk("par_good_err", 32'(bus.parity_err), 32'd0);
    chk("par_good_data", 32'(bus.rx_data), 32'h07);
`endif

    // Leave frame_err set, then reset during bit 3 of 0x5A
    send_frame(8'h66, 1'b1, 1'b0, 0, 8);
    v5a = 8'h5A;
    line(1'b0, CPB);
    for (int i = 0; i < 3; i++) line(v5a[i], CPB);
    line(v5a[3], CPB / 2);
    reset  = 1'b1;
    bus.rx = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_fe  = 1'b0;
    m_pe  = 1'b0;
    chk("mid_reset_rx_data", 32'(bus.rx_data), 32'd0);
    chk("mid_reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("mid_reset_rx_busy", 32'(bus.rx_busy), 32'd0);
    chk("mid_reset_frame_err", 32'(bus.frame_err), 32'd0);
    chk("mid_reset_parity_err", 32'(bus.parity_err), 32'd0);
    line(1'b1, 2 * CPB);
    send_frame(8'h5A, 1'b1, 1'b1, 0, 8);
    chk("resend_5a_data", 32'(bus.rx_data), 32'h5A);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      int kind;
      bit pok;
      kind = int'($urandom_range(0, 9));
      pok  = (PB != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (kind == 0) begin
        false_start(int'($urandom_range(1, 6)));
      end else if (kind == 1) begin
        send_frame(DB'($urandom_range(0, 255)), pok, 1'b0, int'($urandom_range(0, 30)),
                   int'($urandom_range(4, 20)));
      end else begin
        send_frame(DB'($urandom_range(0, 255)), pok, 1'b1, 0, int'($urandom_range(0, 20)));
      end
    end

    line(1'b1, 3 * CPB);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk_flags("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
